// File: rtl/rng_arb_pkg.sv
// Shared types and helpers for the RNG sequencer/arbiter.
// Holds the FSM state encoding, the power-up seed and the round-robin pointer step.
package rng_arb_pkg;

    typedef enum logic [1:0] {
        INIT,
        LOAD,
        WARM,
        RUN
    } rng_arb_state_t;

    localparam logic [31:0] SEED_DEFAULT_C = 32'hACE1_ACE1;

    // Index wide enough for the largest supported requester count (16).
    localparam int IDX_W = 4;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t ptr_next(input idx_t last, input int n_req);
        if (int'(last) >= n_req - 1) begin
            return '0;
        end
        return last + idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set finder: first candidate at or after start_i, wrapping,
// ignoring bits set in excl_i.
module rr_pick
    import rng_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  idx_t         start_i,
    input  logic [N-1:0] excl_i,
    output logic         found_o,
    output idx_t         idx_o
);

    logic [N-1:0] cand;
    logic [N-1:0] rot;
    int           pos;

    assign cand = req_i & ~excl_i;

    // Offsets are walked high to low so the nearest hit to start_i is written last.
    // NOTE: every output and temporary gets a default first so no latch is inferred.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        rot     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            rot = cand >> pos;
            if (rot[0]) begin
                found_o = 1'b1;
                idx_o   = idx_t'(pos);
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Seed/load sequencer and round-robin distributor for the shared LFSR generator.
// Define RNG_ARB_DUAL_EN to grant rnd1 and rnd2 to two winners per cycle.
module rng_arbiter
    import rng_arb_pkg::*;
#(
    parameter int          DATA_W       = 8,
    parameter int          N_REQ        = 4,
    parameter int          WARMUP       = 4,
    parameter logic [31:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reseed_req,
    input  logic [31:0]             reseed_seed,
    output logic [31:0]             rng_seed,
    output logic                    rng_load,
    input  logic [DATA_W-1:0]       rnd1,
    input  logic [DATA_W-1:0]       rnd2,
    input  logic [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ*DATA_W-1:0] gnt_data,
    output logic                    ready
);

    localparam int         GD_W      = N_REQ * DATA_W;
    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    rng_arb_state_t    state_q;
    logic [7:0]        warm_q;
    logic [31:0]       seed_q;
    logic              rng_load_q;
    logic              ready_q;
    idx_t              ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [GD_W-1:0]   gnt_data_q, gnt_data_d;

    logic              arb_en;
    logic              a_found;
    idx_t              a_idx;

    // Grants need RUN on two consecutive edges, so the warm-up discards exactly
    // WARMUP generator words and no grant ever precedes ready.
    assign arb_en = ready_q && (state_q == RUN) && !reseed_req;

    rr_pick #(.N(N_REQ)) u_pick_a (
        .req_i   (req),
        .start_i (ptr_q),
        .excl_i  ('0),
        .found_o (a_found),
        .idx_o   (a_idx)
    );

`ifdef RNG_ARB_DUAL_EN
    logic b_found;
    idx_t b_idx;

    rr_pick #(.N(N_REQ)) u_pick_b (
        .req_i   (req),
        .start_i (ptr_next(a_idx, N_REQ)),
        .excl_i  (N_REQ'(1) << a_idx),
        .found_o (b_found),
        .idx_o   (b_idx)
    );

    always_comb begin
        gnt_d      = '0;
        gnt_data_d = '0;
        ptr_d      = ptr_q;
        if (arb_en && a_found) begin
            gnt_d      = N_REQ'(1) << a_idx;
            gnt_data_d = GD_W'(rnd1) << (int'(a_idx) * DATA_W);
            ptr_d      = ptr_next(a_idx, N_REQ);
            if (b_found) begin
                gnt_d      |= N_REQ'(1) << b_idx;
                gnt_data_d |= GD_W'(rnd2) << (int'(b_idx) * DATA_W);
                ptr_d       = ptr_next(b_idx, N_REQ);
            end
        end
    end
`else
    logic unused_rnd2;
    assign unused_rnd2 = ^rnd2;

    always_comb begin
        gnt_d      = '0;
        gnt_data_d = '0;
        ptr_d      = ptr_q;
        if (arb_en && a_found) begin
            gnt_d      = N_REQ'(1) << a_idx;
            gnt_data_d = GD_W'(rnd1) << (int'(a_idx) * DATA_W);
            ptr_d      = ptr_next(a_idx, N_REQ);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            warm_q     <= '0;
            seed_q     <= SEED_DEFAULT;
            rng_load_q <= 1'b0;
            ready_q    <= 1'b0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            gnt_data_q <= '0;
        end else begin
            rng_load_q <= (state_q == LOAD);
            ready_q    <= (state_q == RUN);
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            gnt_data_q <= gnt_data_d;
            if (reseed_req && (state_q != INIT)) begin
                seed_q  <= reseed_seed;
                state_q <= LOAD;
            end else begin
                case (state_q)
                    INIT: state_q <= LOAD;
                    LOAD: begin
                        state_q <= WARM;
                        warm_q  <= '0;
                    end
                    WARM: begin
                        if (warm_q == WARM_LAST) begin
                            state_q <= RUN;
                        end else begin
                            warm_q <= warm_q + 8'd1;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign rng_seed = seed_q;
    assign rng_load = rng_load_q;
    assign ready    = ready_q;
    assign gnt      = gnt_q;
    assign gnt_data = gnt_data_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter driving a model LFSR generator (taps 31,21,1,0).
`timescale 1ns/1ps
module tb_rng_arbiter;

    localparam int          DATA_W = 8;
    localparam int          N_REQ  = 4;
    localparam int          WARMUP = 4;
    localparam logic [31:0] SEED0  = 32'hACE1_ACE1;
    localparam logic [31:0] SEED1  = 32'h1234_5678;
    localparam logic [31:0] SEED2  = 32'hFFFF_0000;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    reseed_req = 1'b0;
    logic [31:0]             reseed_seed = '0;
    logic [31:0]             rng_seed;
    logic                    rng_load;
    logic [DATA_W-1:0]       rnd1, rnd2;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ*DATA_W-1:0] gnt_data;
    logic                    ready;

    always #5 clk = ~clk;

    rng_arbiter #(
        .DATA_W       (DATA_W),
        .N_REQ        (N_REQ),
        .WARMUP       (WARMUP),
        .SEED_DEFAULT (SEED0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reseed_req  (reseed_req),
        .reseed_seed (reseed_seed),
        .rng_seed    (rng_seed),
        .rng_load    (rng_load),
        .rnd1        (rnd1),
        .rnd2        (rnd2),
        .req         (req),
        .gnt         (gnt),
        .gnt_data    (gnt_data),
        .ready       (ready)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    // External generator: synchronous load from rng_seed, otherwise free-running.
    logic [31:0] gen_q = 32'h1;
    always @(posedge clk) gen_q <= rng_load ? rng_seed : lfsr_step(gen_q);
    assign rnd1 = gen_q[7:0];
    assign rnd2 = gen_q[15:8];

    typedef struct packed {
        logic [N_REQ-1:0]        gnt;
        logic [N_REQ*DATA_W-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          k = 0;
    logic [31:0] cur_seed = SEED0;
    int          load_k = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    endtask

    // Monitor: every presented grant is matched against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (gnt !== '0) begin
            if (exp_q.size() == 0) begin
                check("gnt_unexpected", 64'(gnt), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("gnt", 64'(gnt), 64'(e.gnt));
                check("gnt_data", 64'(gnt_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    // Expectation for the next edge: winner ia gets rnd1, ib (if >= 0) gets rnd2,
    // where the generator word is the seed advanced by the cycles since its load.
    task automatic expect_gnt(input int ia, input int ib);
        logic [31:0] s;
        exp_t        e;
        s      = lfsr_adv(cur_seed, k - load_k);
        e.gnt  = '0;
        e.data = '0;
        e.gnt[ia] = 1'b1;
        e.data[ia*DATA_W +: DATA_W] = s[7:0];
        if (ib >= 0) begin
            e.gnt[ib] = 1'b1;
            e.data[ib*DATA_W +: DATA_W] = s[15:8];
        end
        exp_q.push_back(e);
    endtask

    // Release reset just before edge 0 and walk INIT -> LOAD -> WARM -> RUN.
    task automatic startup(input string tag);
        @(negedge clk);
        reset = 1'b1;
        k = -1;
        for (int e = 0; e <= 2 + WARMUP; e++) begin
            tick();
            check({tag, "_rng_load"}, 64'(rng_load), 64'(k == 1));
            check({tag, "_ready"}, 64'(ready), 64'(k == 2 + WARMUP));
            if (k == 1) check({tag, "_rng_seed"}, 64'(rng_seed), 64'(SEED0));
        end
        cur_seed = SEED0;
        load_k   = 2;
    endtask

    initial begin
        int u;
        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_gnt_data", 64'(gnt_data), 64'd0);
        check("rst_rng_load", 64'(rng_load), 64'd0);
        check("rst_rng_seed", 64'(rng_seed), 64'(SEED0));
        check("rst_ready", 64'(ready), 64'd0);

        startup("por");

`ifdef RNG_ARB_DUAL_EN
        req = 4'b1111;
        expect_gnt(0, 1); tick();
        expect_gnt(2, 3); tick();
        expect_gnt(0, 1); tick();
        expect_gnt(2, 3); tick();
        expect_gnt(0, 1); tick();
`else
        req = 4'b1111;
        expect_gnt(0, -1); tick();
        expect_gnt(1, -1); tick();
        expect_gnt(2, -1); tick();
        expect_gnt(3, -1); tick();
        expect_gnt(0, -1); tick();
`endif
        req = 4'b0100;
        expect_gnt(2, -1); tick();
        expect_gnt(2, -1); tick();
        expect_gnt(2, -1); tick();

        // Reseed from RUN while all requesters are active: that edge grants nothing.
        req = 4'b1111;
        reseed_req = 1'b1;
        reseed_seed = SEED1;
        tick();
        reseed_req = 1'b0;
        check("rs_run_ready_t", 64'(ready), 64'd1);
        check("rs_run_load_t", 64'(rng_load), 64'd0);
        tick();
        check("rs_run_ready_t1", 64'(ready), 64'd0);
        check("rs_run_load_t1", 64'(rng_load), 64'd1);
        check("rs_run_seed", 64'(rng_seed), 64'(SEED1));
        tick();
        check("rs_run_load_t2", 64'(rng_load), 64'd0);

        // Second reseed lands in WARM and restarts the sequence with the new seed.
        reseed_req = 1'b1;
        reseed_seed = SEED2;
        tick();
        reseed_req = 1'b0;
        u = k;
        check("rs_warm_ready_u", 64'(ready), 64'd0);
        check("rs_warm_load_u", 64'(rng_load), 64'd0);
        for (int j = 1; j <= 2 + WARMUP; j++) begin
            tick();
            check("rs_warm_rng_load", 64'(rng_load), 64'(k == u + 1));
            check("rs_warm_ready", 64'(ready), 64'(k == u + 2 + WARMUP));
            if (k == u + 1) check("rs_warm_rng_seed", 64'(rng_seed), 64'(SEED2));
        end
        cur_seed = SEED2;
        load_k   = u + 2;

`ifdef RNG_ARB_DUAL_EN
        expect_gnt(3, 0); tick();
        req = 4'b0011;
        expect_gnt(1, 0); tick();
`else
        expect_gnt(3, -1); tick();
        expect_gnt(0, -1); tick();
`endif

        // Asynchronous reset while a grant is on the outputs.
        check("pre_rst_gnt_nonzero", 64'(gnt != '0), 64'd1);
        reset = 1'b0;
        req = '0;
        #1;
        check("async_rst_gnt", 64'(gnt), 64'd0);
        check("async_rst_gnt_data", 64'(gnt_data), 64'd0);
        check("async_rst_ready", 64'(ready), 64'd0);
        check("async_rst_rng_load", 64'(rng_load), 64'd0);
        check("async_rst_rng_seed", 64'(rng_seed), 64'(SEED0));
        @(negedge clk);

        startup("rst2");
        req = 4'b0001;
        expect_gnt(0, -1); tick();
        req = '0;
        tick();
        tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
